// File: rtl/load_issue_queue.sv
// Load issue queue: in-order FIFO of address-computed loads that feeds a
// single-outstanding load unit and broadcasts returned data with its tag.
module load_issue_queue #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 5,
   parameter int ADDR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [ADDR_W-1:0]          disp_base,
   input  logic [ADDR_W-1:0]          disp_offset,
   input  logic [TAG_W-1:0]           disp_tag,
   output logic                       lu_set_busy,
   output logic [ADDR_W-1:0]          lu_addr,
   input  logic                       lu_busy,
   input  logic                       lu_valid,
   input  logic [ADDR_W-1:0]          lu_data,
   output logic                       wb_valid,
   output logic [TAG_W-1:0]           wb_tag,
   output logic [ADDR_W-1:0]          wb_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0]        addr_mem [DEPTH];
   logic [TAG_W-1:0]         tag_mem  [DEPTH];
   logic [PTR_W-1:0]         rd_ptr, wr_ptr;
   logic [TAG_W-1:0]         inflight_tag;
   logic                     squash;
   logic                     push, issue, wb_fire;
   logic signed [ADDR_W-1:0] addr_p0;

   // Two's-complement add at ADDR_W bits: the carry out is simply discarded.
   function automatic logic signed [ADDR_W-1:0] wrap_add(
      input logic signed [ADDR_W-1:0] a,
      input logic signed [ADDR_W-1:0] b
   );
      return a + b;
   endfunction

   assign disp_ready = (count != FULL);
   assign push       = disp_valid && disp_ready && !flush;
   assign addr_p0    = wrap_add($signed(disp_base), $signed(disp_offset));

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      wb_fire   = 1'b0;
      case (state)
         IDLE: if (count != '0 && !lu_busy && !flush) begin
            issue     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (lu_valid) begin
            wb_fire   = !squash && !flush;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Stage p0 -> storage: entries carry the precomputed address with the tag.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= addr_p0;
         tag_mem[wr_ptr]  <= disp_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         lu_set_busy  <= 1'b0;
         lu_addr      <= '0;
         inflight_tag <= '0;
         squash       <= 1'b0;
         wb_valid     <= 1'b0;
         wb_tag       <= '0;
         wb_data      <= '0;
      end else begin
         lu_set_busy <= issue;
         wb_valid    <= wb_fire;
         if (issue) begin
            lu_addr      <= addr_mem[rd_ptr];
            inflight_tag <= tag_mem[rd_ptr];
         end
         if (wb_fire) begin
            wb_tag  <= inflight_tag;
            wb_data <= lu_data;
         end
         // A flushed in-flight load still has to be drained from the unit.
         if (state == WAIT) squash <= lu_valid ? 1'b0 : (squash | flush);
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            if (push && !issue)      count <= count + 1'b1;
            else if (!push && issue) count <= count - 1'b1;
         end
      end
   end
endmodule

// File: doc/load_issue_queue.md
Name: load_issue_queue

Overview:
- Sits directly upstream of the load unit. Accepts load micro-ops from dispatch, computes the effective address, and buffers entries in an in-order FIFO.
- Issues one load at a time to the load unit's set_busy/addr interface.
- Captures the returned data on the load unit's valid pulse and broadcasts it with its destination tag on a one-cycle writeback port.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
TAG_W, 5, destination tag width
ADDR_W, 32, address/data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  discard all queued loads and squash in-flight result
disp_valid  in  1  dispatch offers a load
disp_ready  out  1  queue can accept (count < DEPTH)
disp_base  in  ADDR_W  base register value
disp_offset  in  ADDR_W  sign-extended immediate
disp_tag  in  TAG_W  destination tag
lu_set_busy  out  1  start pulse to load unit
lu_addr  out  ADDR_W  address to load unit
lu_busy  in  1  load unit busy
lu_valid  in  1  load unit data valid (one-cycle pulse)
lu_data  in  ADDR_W  load unit data
wb_valid  out  1  writeback pulse
wb_tag  out  TAG_W  writeback tag
wb_data  out  ADDR_W  writeback data
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst high, async): state=IDLE; rd/wr pointers=0; count=0; lu_set_busy=0; lu_addr=0; wb_valid=0; wb_tag=0; wb_data=0; squash=0. Reset mid-operation abandons any in-flight load. The load unit shares the reset net.
- Address: entry addr = disp_base + disp_offset, modulo 2^ADDR_W. Carry is dropped; no alignment check. The sum is computed at push and stored with the tag.
- disp_ready = (count != DEPTH), combinational from registered count.
- Push occurs when disp_valid && disp_ready && !flush. disp_valid while full is ignored; the entry is not stored.
- Pop occurs only at issue. If push and pop happen on the same edge, count is unchanged. Pointers wrap modulo DEPTH.
- FSM IDLE:
  - If count!=0 && !lu_busy && !flush: at next edge lu_set_busy<=1, lu_addr<=head addr, inflight_tag<=head tag, pop, state<=WAIT.
  - A push into an empty queue is not visible until the following cycle (no bypass).
- FSM WAIT:
  - lu_set_busy<=0 (high exactly one cycle per issue). lu_addr holds its value.
  - On lu_valid: if !squash, then wb_valid<=1, wb_data<=lu_data, wb_tag<=inflight_tag. squash<=0; state<=IDLE.
  - lu_valid in IDLE is ignored.
- wb_valid is a one-cycle pulse; it is cleared on the next edge.
- Back-to-back issue: the next lu_set_busy may rise at the edge after the WAIT->IDLE transition, provided lu_busy=0.
- Latency, empty queue with idle unit:
  - push at edge E0
  - lu_set_busy=1 after E1
  - lu_busy=1 after E2
  - lu_valid=1 after E3
  - wb_valid=1 after E4
  - Dispatch-to-writeback: 4 cycles. Throughput: 1 load per 4 cycles.
- flush:
  - At the next edge: count=0 and pointers reset.
  - A push in the same cycle is dropped.
  - If state is WAIT, or the issue edge coincides with flush: squash<=1. The FSM still waits for lu_valid to stay aligned with the load unit, then returns to IDLE with no writeback.
  - Flush in IDLE with empty queue: no effect.
- flush and lu_valid in the same WAIT cycle: the result is suppressed.

Test Plan:
- Reset, then one push (base=0x1000, offset=0x0000_0010, tag=3); model unit (busy 1 cycle later, valid 1 cycle after) returns 0xDEADBEEF -> lu_addr=0x1010 with lu_set_busy high exactly 1 cycle; wb_valid 1 cycle, wb_tag=3, wb_data=0xDEADBEEF, 4 cycles after push.
- Negative offset and wrap: base=0x0000_0004, offset=0xFFFF_FFF8 -> lu_addr=0xFFFF_FFFC; base=0xFFFF_FFF0, offset=0x20 -> lu_addr=0x0000_0010.
- Push 5 loads (tags 1..5) with the load unit held busy: after 4 pushes, disp_ready=0 and count=4; the 5th is dropped. Release the unit -> writebacks in tag order 1,2,3,4 with no tag 5 and no duplicates.
- Push and issue on the same edge with count=2 -> count stays 2. Continuous dispatch stream -> issues spaced exactly 4 cycles apart.
- flush asserted in the cycle after lu_set_busy, with 3 entries queued -> count=0 next cycle. The in-flight lu_valid produces no wb_valid. A new push afterward issues normally and writes back.
- Assert rst for 1 cycle mid-WAIT with 2 entries queued -> all outputs 0, count=0; subsequent operation matches the first scenario.
